// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer encodings, response codes, slave
// count, the default-slave state type and a lowest-bit select helper.
package ahb_pkg;

  localparam int AHB_NUM_SLAVES = 5;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_ERR1 = 2'b01,
    D_ERR2 = 2'b10
  } dflt_state_e;

  // Keep only the lowest set bit, so a malformed multi-hot select still
  // produces a one-hot data-phase owner.
  function automatic logic [AHB_NUM_SLAVES-1:0] lowest_set(
    input logic [AHB_NUM_SLAVES-1:0] v
  );
    return v & (~v + AHB_NUM_SLAVES'(1));
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Built-in default slave: answers active transfers to unmapped addresses
// with the two-cycle AHB ERROR response and counts those responses.
module ahblite_default_slave
  import ahb_pkg::*;
#(
  parameter bit ERR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic        unmapped_active,
  output logic        hready,
  output logic        hresp,
  output logic [15:0] err_cnt
);

  dflt_state_e state_q;
  dflt_state_e state_d;
  logic [15:0] err_cnt_q;

  logic start_err;
  assign start_err = sample && unmapped_active && ERR_EN;

  // State register; synchronous reset abandons any response in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= D_IDLE;
    else     state_q <= state_d;
  end

  // Next state and response outputs for the error sequence.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    hready  = 1'b1;
    hresp   = HRESP_OKAY;
    unique case (state_q)
      D_IDLE: begin
        if (start_err) state_d = D_ERR1;
      end
      D_ERR1: begin
        hready  = 1'b0;
        hresp   = HRESP_ERROR;
        state_d = D_ERR2;
      end
      D_ERR2: begin
        // Second error cycle is also an address-sampling edge.
        hresp   = HRESP_ERROR;
        state_d = start_err ? D_ERR1 : D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  // Saturating error counter, bumped as the response enters its final cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 16'h0000;
    end else if (state_q == D_ERR1 && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase multiplexer: registers the decoder's slave select in
// the address phase and routes that slave's response back to the master.
module ahblite_slave_mux
  import ahb_pkg::*;
#(
  parameter logic [31:0] DEFAULT_RDATA  = 32'h0000_0000,
  parameter bit          DEFAULT_ERR_EN = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P4_HSEL,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P4_HRDATA,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P4_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P4_HRESP,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [15:0] ERR_CNT
);

  logic [AHB_NUM_SLAVES-1:0] hsel;
  logic [AHB_NUM_SLAVES-1:0] sel_q;
  logic [31:0]               rdata    [AHB_NUM_SLAVES];
  logic [AHB_NUM_SLAVES-1:0] readyout;
  logic [AHB_NUM_SLAVES-1:0] resp;

  assign hsel     = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
  assign readyout = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
  assign resp     = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
  assign rdata[0] = P0_HRDATA;
  assign rdata[1] = P1_HRDATA;
  assign rdata[2] = P2_HRDATA;
  assign rdata[3] = P3_HRDATA;
  assign rdata[4] = P4_HRDATA;

  // Active (NONSEQ/SEQ) transfer that no slave claims.
  logic unmapped_active;
  assign unmapped_active = (hsel == '0) &&
                           (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

  logic        dflt_hready;
  logic        dflt_hresp;

  ahblite_default_slave #(
    .ERR_EN (DEFAULT_ERR_EN)
  ) u_default (
    .clk             (HCLK),
    .rst             (HRESET),
    .sample          (HREADY),
    .unmapped_active (unmapped_active),
    .hready          (dflt_hready),
    .hresp           (dflt_hresp),
    .err_cnt         (ERR_CNT)
  );

  // Data-phase owner, captured only when the bus completes a cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET)      sel_q <= '0;
    else if (HREADY) sel_q <= lowest_set(hsel);
  end

  // Route the owning slave's response; the default slave answers otherwise.
  always_comb begin
    HRDATA = DEFAULT_RDATA;
    HREADY = dflt_hready;
    HRESP  = dflt_hresp;
    for (int i = 0; i < AHB_NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        HRDATA = rdata[i];
        HREADY = readyout[i];
        HRESP  = resp[i];
      end
    end
  end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Self-checking bench for ahblite_slave_mux: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction-level
// model every cycle.
module tb_ahblite_slave_mux;
  import ahb_pkg::*;

  localparam logic [31:0] DEF_RDATA  = 32'h0000_0000;
  localparam bit          DEF_ERR_EN = 1'b1;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  HTRANS;
  logic [4:0]  hsel;
  logic [31:0] rd [5];
  logic [4:0]  rdy;
  logic [4:0]  rsp;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [15:0] ERR_CNT;

  ahblite_slave_mux #(
    .DEFAULT_RDATA  (DEF_RDATA),
    .DEFAULT_ERR_EN (DEF_ERR_EN)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HTRANS       (HTRANS),
    .P0_HSEL      (hsel[0]),
    .P1_HSEL      (hsel[1]),
    .P2_HSEL      (hsel[2]),
    .P3_HSEL      (hsel[3]),
    .P4_HSEL      (hsel[4]),
    .P0_HRDATA    (rd[0]),
    .P1_HRDATA    (rd[1]),
    .P2_HRDATA    (rd[2]),
    .P3_HRDATA    (rd[3]),
    .P4_HRDATA    (rd[4]),
    .P0_HREADYOUT (rdy[0]),
    .P1_HREADYOUT (rdy[1]),
    .P2_HREADYOUT (rdy[2]),
    .P3_HREADYOUT (rdy[3]),
    .P4_HREADYOUT (rdy[4]),
    .P0_HRESP     (rsp[0]),
    .P1_HRESP     (rsp[1]),
    .P2_HRESP     (rsp[2]),
    .P3_HRESP     (rsp[3]),
    .P4_HRESP     (rsp[4]),
    .HRDATA       (HRDATA),
    .HREADY       (HREADY),
    .HRESP        (HRESP),
    .ERR_CNT      (ERR_CNT)
  );

  always #5 HCLK = ~HCLK;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;
  bit preload  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model at transaction level: who owns the current data phase
  // (-1 = nobody), which cycle of an error response we are in (0 none,
  // 1 first, 2 second) and the number of error responses given so far.
  int          m_owner = -1;
  int          m_err   = 0;
  logic [15:0] m_cnt   = 16'h0000;

  function automatic void expected(output logic [31:0] d, output logic r, output logic e);
    if (m_owner >= 0) begin
      d = rd[m_owner];
      r = rdy[m_owner];
      e = rsp[m_owner];
    end else begin
      d = DEF_RDATA;
      r = (m_err != 1);
      e = (m_err != 0);
    end
  endfunction

  // Advance the model by one bus cycle.
  always @(posedge HCLK) begin
    logic [31:0] d;
    logic        r, e;
    expected(d, r, e);
    if (HRESET) begin
      m_owner = -1;
      m_err   = 0;
      m_cnt   = 16'h0000;
    end else if (m_err == 1) begin
      m_err = 2;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (r) begin
      m_owner = -1;
      m_err   = 0;
      for (int i = 0; i < 5; i++) begin
        if (hsel[i] && m_owner < 0) m_owner = i;
      end
      if (m_owner < 0 && HTRANS[1] && DEF_ERR_EN) m_err = 1;
    end
    if (preload) m_cnt = 16'hFFFE;
  end

  // Compare every output against the model mid-cycle.
  always @(negedge HCLK) begin
    logic [31:0] d;
    logic        r, e;
    if (check_en) begin
      expected(d, r, e);
      check("model_hrdata", HRDATA, d);
      check("model_hready", 32'(HREADY), 32'(r));
      check("model_hresp", 32'(HRESP), 32'(e));
      check("model_err_cnt", 32'(ERR_CNT), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    hsel   = '0;
    HTRANS = HTRANS_IDLE;
  endtask

  initial begin
    HRESET = 1'b1;
    idle_bus();
    rdy = '1;
    rsp = '0;
    for (int i = 0; i < 5; i++) rd[i] = 32'h0;

    // Reset: two cycles, then idle outputs.
    step();
    step();
    HRESET   = 1'b0;
    check_en = 1'b1;
    @(negedge HCLK);
    check("rst_hready", 32'(HREADY), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_err_cnt", 32'(ERR_CNT), 32'd0);

    // Single read from P1.
    hsel   = 5'b00010;
    HTRANS = HTRANS_NONSEQ;
    rd[1]  = 32'hCAFE_0001;
    step();
    idle_bus();
    @(negedge HCLK);
    check("p1_hrdata", HRDATA, 32'hCAFE_0001);
    check("p1_hready", 32'(HREADY), 32'd1);
    check("p1_hresp", 32'(HRESP), 32'd0);

    // P3 with three wait states while P0 is already decoded.
    step();
    hsel   = 5'b01000;
    HTRANS = HTRANS_NONSEQ;
    rd[3]  = 32'h6910_0003;
    rd[0]  = 32'h0000_A000;
    step();
    hsel   = 5'b00001;
    rdy[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      check("p3_wait_hready", 32'(HREADY), 32'd0);
      check("p3_wait_hrdata", HRDATA, 32'h6910_0003);
      step();
    end
    rdy[3] = 1'b1;
    @(negedge HCLK);
    check("p3_done_hready", 32'(HREADY), 32'd1);
    check("p3_done_hrdata", HRDATA, 32'h6910_0003);
    step();
    idle_bus();
    @(negedge HCLK);
    check("p0_after_wait", HRDATA, 32'h0000_A000);
    step();

    // Active transfer to an unmapped address, then IDLE to the same address.
    HTRANS = HTRANS_NONSEQ;
    step();
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    check("err1_hready", 32'(HREADY), 32'd0);
    check("err1_hresp", 32'(HRESP), 32'd1);
    step();
    @(negedge HCLK);
    check("err2_hready", 32'(HREADY), 32'd1);
    check("err2_hresp", 32'(HRESP), 32'd1);
    check("err2_err_cnt", 32'(ERR_CNT), 32'd1);
    step();
    @(negedge HCLK);
    check("idle_unmapped_hresp", 32'(HRESP), 32'd0);
    check("idle_unmapped_cnt", 32'(ERR_CNT), 32'd1);

    // Back-to-back P0 -> P4 -> P2.
    rd[0]  = 32'h11;
    rd[4]  = 32'h44;
    rd[2]  = 32'h22;
    hsel   = 5'b00001;
    HTRANS = HTRANS_NONSEQ;
    step();
    hsel = 5'b10000;
    @(negedge HCLK);
    check("b2b_p0", HRDATA, 32'h11);
    step();
    hsel = 5'b00100;
    @(negedge HCLK);
    check("b2b_p4", HRDATA, 32'h44);
    step();
    idle_bus();
    @(negedge HCLK);
    check("b2b_p2", HRDATA, 32'h22);
    check("b2b_hready", 32'(HREADY), 32'd1);
    step();

    // Reset during the first error cycle.
    HTRANS = HTRANS_NONSEQ;
    step();
    HTRANS = HTRANS_IDLE;
    HRESET = 1'b1;
    @(negedge HCLK);
    check("rst_in_err1_hready", 32'(HREADY), 32'd0);
    step();
    HRESET = 1'b0;
    @(negedge HCLK);
    check("after_rst_hready", 32'(HREADY), 32'd1);
    check("after_rst_hresp", 32'(HRESP), 32'd0);
    check("after_rst_cnt", 32'(ERR_CNT), 32'd0);
    step();

    // Randomized traffic including stalls, multi-hot selects and resets.
    for (int n = 0; n < 800; n++) begin
      int kind;
      HRESET = ($urandom_range(0, 63) == 0);
      kind   = $urandom_range(0, 9);
      if (kind < 2)       hsel = '0;
      else if (kind == 2) hsel = 5'($urandom_range(0, 31));
      else                hsel = 5'(1 << $urandom_range(0, 4));
      HTRANS = 2'($urandom_range(0, 3));
      for (int i = 0; i < 5; i++) begin
        rd[i]  = $urandom;
        rdy[i] = ($urandom_range(0, 3) != 0);
        rsp[i] = ($urandom_range(0, 7) == 0);
      end
      step();
    end

    // Counter saturation: preload near the top, then two more errors.
    HRESET = 1'b1;
    idle_bus();
    rdy = '1;
    rsp = '0;
    step();
    HRESET = 1'b0;
    step();
    check_en = 1'b0;
    force dut.u_default.err_cnt_q = 16'hFFFE;
    preload = 1'b1;
    step();
    release dut.u_default.err_cnt_q;
    preload  = 1'b0;
    check_en = 1'b1;
    HTRANS   = HTRANS_NONSEQ;
    step();
    step();
    @(negedge HCLK);
    check("sat_reach_ffff", 32'(ERR_CNT), 32'h0000_FFFF);
    step();
    HTRANS = HTRANS_IDLE;
    step();
    @(negedge HCLK);
    check("sat_hold_ffff", 32'(ERR_CNT), 32'h0000_FFFF);
    check("sat_err2_hresp", 32'(HRESP), 32'd1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
